// File: rtl/orion_mem_stage.sv
// Orion RV32I memory stage: issues data-memory loads/stores over a valid/ack bus
// and produces the registered writeback bundle plus a forwarding copy for decode.
package orion_types;
  localparam int XLEN  = 32;
  localparam int ADDRW = 32;
  localparam int MASKW = 4;
  localparam int DATAW = 32;

  // ld_str_type follows the RV32I funct3 encoding: [1:0] = size, [2] = unsigned
  localparam logic [2:0] LS_B  = 3'b000;
  localparam logic [2:0] LS_H  = 3'b001;
  localparam logic [2:0] LS_W  = 3'b010;
  localparam logic [2:0] LS_BU = 3'b100;
  localparam logic [2:0] LS_HU = 3'b101;

  typedef struct packed {
    logic [31:0]     pc;
    logic [31:0]     instr;
    logic            rd_we;
    logic [XLEN-1:0] rd_v;
  } debug_t;

  typedef struct packed {
    logic            valid;
    logic [4:0]      rd_s;
    logic            rd_we;
    logic [XLEN-1:0] rd_v;
    logic            is_load;
    logic            is_store;
    logic [2:0]      ld_str_type;
    debug_t          debug;
  } ex_mem_t;

  typedef struct packed {
    logic            valid;
    logic [4:0]      rd_s;
    logic            rd_we;
    logic [XLEN-1:0] rd_v;
    debug_t          debug;
  } mem_wb_t;

  typedef struct packed {
    logic            valid;
    logic            rd_we;
    logic [4:0]      rd_s;
    logic [XLEN-1:0] rd_v;
  } mem_id_t;
endpackage

module orion_mem_stage
  import orion_types::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  ex_mem_t          ex_mem_i,
  input  logic [XLEN-1:0]  ex_mem_sdata_i,
  output logic             ex_mem_ready_o,
  output mem_wb_t          mem_wb_o,
  output mem_id_t          mem_id_o,
  output logic             misalign_o,
  output logic [ADDRW-1:0] dmem_addr_o,
  output logic             dmem_valid_o,
  output logic             dmem_we_o,
  output logic [MASKW-1:0] dmem_mask_o,
  output logic [DATAW-1:0] dmem_wdata_o,
  input  logic [DATAW-1:0] dmem_rdata_i,
  input  logic             dmem_ack_i
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state;
  mem_wb_t          wb_q;
  logic             misalign_q;
  logic [ADDRW-1:0] dmem_addr_q;
  logic             dmem_valid_q;
  logic             dmem_we_q;
  logic [MASKW-1:0] dmem_mask_q;
  logic [DATAW-1:0] dmem_wdata_q;
  logic [4:0]       rd_s_q;
  logic             rd_we_q;
  logic [2:0]       type_q;
  logic             is_load_q;
  logic [1:0]       off_q;
  debug_t           dbg_q;

  logic             transfer;
  logic             is_mem;
  logic [1:0]       off;
  logic             misaligned;
  logic [DATAW-1:0] st_wdata;
  logic [MASKW-1:0] st_mask;
  logic [7:0]       ld_byte;
  logic [15:0]      ld_half;
  logic [XLEN-1:0]  ld_data;
  logic             nm_we;
  logic             bus_we;
  mem_wb_t          idle_wb;
  mem_wb_t          busy_wb;

  assign transfer   = ex_mem_i.valid && (state == IDLE);
  assign is_mem     = ex_mem_i.is_load || ex_mem_i.is_store;
  assign off        = ex_mem_i.rd_v[1:0];
  assign misaligned = is_mem &&
                      (((ex_mem_i.ld_str_type[1:0] == 2'b01) && off[0]) ||
                       ((ex_mem_i.ld_str_type[1:0] == 2'b10) && (off != 2'b00)));

  // Stores replicate the data across all lanes so the mask alone selects the bytes
  always_comb begin
    st_wdata = ex_mem_sdata_i;
    st_mask  = 4'hF;
    if (ex_mem_i.is_store) begin
      case (ex_mem_i.ld_str_type[1:0])
        2'b00: begin
          st_wdata = {4{ex_mem_sdata_i[7:0]}};
          st_mask  = 4'b0001 << off;
        end
        2'b01: begin
          st_wdata = {2{ex_mem_sdata_i[15:0]}};
          st_mask  = 4'b0011 << off;
        end
        default: ;
      endcase
    end else begin
      st_wdata = '0;
    end
  end

  assign ld_byte = dmem_rdata_i[{off_q, 3'b000} +: 8];
  assign ld_half = dmem_rdata_i[{off_q[1], 4'b0000} +: 16];

  always_comb begin
    ld_data = dmem_rdata_i;
    case (type_q)
      LS_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
      LS_BU:   ld_data = {24'd0, ld_byte};
      LS_H:    ld_data = {{16{ld_half[15]}}, ld_half};
      LS_HU:   ld_data = {16'd0, ld_half};
      default: ld_data = dmem_rdata_i;
    endcase
  end

  assign nm_we  = !is_mem && ex_mem_i.rd_we && (ex_mem_i.rd_s != 5'd0);
  assign bus_we = is_load_q && rd_we_q && (rd_s_q != 5'd0);

  // Results retired straight from IDLE: ALU pass-through or a dropped misaligned access
  always_comb begin
    idle_wb             = '0;
    idle_wb.valid       = 1'b1;
    idle_wb.rd_s        = ex_mem_i.rd_s;
    idle_wb.rd_we       = nm_we;
    idle_wb.rd_v        = ex_mem_i.rd_v;
    idle_wb.debug       = ex_mem_i.debug;
    idle_wb.debug.rd_v  = ex_mem_i.rd_v;
    idle_wb.debug.rd_we = nm_we;
  end

  always_comb begin
    busy_wb             = '0;
    busy_wb.valid       = 1'b1;
    busy_wb.rd_s        = rd_s_q;
    busy_wb.rd_we       = bus_we;
    busy_wb.rd_v        = is_load_q ? ld_data : {dmem_addr_q[ADDRW-1:2], off_q};
    busy_wb.debug       = dbg_q;
    busy_wb.debug.rd_v  = busy_wb.rd_v;
    busy_wb.debug.rd_we = bus_we;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      wb_q         <= '0;
      misalign_q   <= 1'b0;
      dmem_addr_q  <= '0;
      dmem_valid_q <= 1'b0;
      dmem_we_q    <= 1'b0;
      dmem_mask_q  <= '0;
      dmem_wdata_q <= '0;
      rd_s_q       <= '0;
      rd_we_q      <= 1'b0;
      type_q       <= '0;
      is_load_q    <= 1'b0;
      off_q        <= '0;
      dbg_q        <= '0;
    end else begin
      wb_q.valid <= 1'b0;
      misalign_q <= 1'b0;
      case (state)
        IDLE: begin
          if (transfer) begin
            if (!is_mem || misaligned) begin
              wb_q       <= idle_wb;
              misalign_q <= misaligned;
            end else begin
              rd_s_q       <= ex_mem_i.rd_s;
              rd_we_q      <= ex_mem_i.rd_we;
              type_q       <= ex_mem_i.ld_str_type;
              is_load_q    <= ex_mem_i.is_load;
              off_q        <= off;
              dbg_q        <= ex_mem_i.debug;
              dmem_addr_q  <= {ex_mem_i.rd_v[ADDRW-1:2], 2'b00};
              dmem_valid_q <= 1'b1;
              dmem_we_q    <= ex_mem_i.is_store;
              dmem_mask_q  <= st_mask;
              dmem_wdata_q <= st_wdata;
              state        <= BUSY;
            end
          end
        end
        BUSY: begin
          if (dmem_ack_i) begin
            wb_q         <= busy_wb;
            dmem_valid_q <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ex_mem_ready_o = (state == IDLE);
  assign mem_wb_o       = wb_q;
  assign misalign_o     = misalign_q;
  assign dmem_addr_o    = dmem_addr_q;
  assign dmem_valid_o   = dmem_valid_q;
  assign dmem_we_o      = dmem_we_q;
  assign dmem_mask_o    = dmem_mask_q;
  assign dmem_wdata_o   = dmem_wdata_q;

  assign mem_id_o.valid = wb_q.valid;
  assign mem_id_o.rd_we = wb_q.rd_we;
  assign mem_id_o.rd_s  = wb_q.rd_s;
  assign mem_id_o.rd_v  = wb_q.rd_v;

endmodule

// File: tb/tb_orion_mem_stage.sv
// Randomized self-checking bench for orion_mem_stage against a transaction-level
// reference model of load/store formatting, handshake timing and retirement.
module tb_orion_mem_stage;
  import orion_types::*;

  logic        clk = 1'b0;
  logic        rst_n;
  ex_mem_t     ex_mem_i;
  logic [31:0] ex_mem_sdata_i;
  logic        ex_mem_ready_o;
  mem_wb_t     mem_wb_o;
  mem_id_t     mem_id_o;
  logic        misalign_o;
  logic [31:0] dmem_addr_o;
  logic        dmem_valid_o;
  logic        dmem_we_o;
  logic [3:0]  dmem_mask_o;
  logic [31:0] dmem_wdata_o;
  logic [31:0] dmem_rdata_i;
  logic        dmem_ack_i;

  orion_mem_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ex_mem_i       (ex_mem_i),
    .ex_mem_sdata_i (ex_mem_sdata_i),
    .ex_mem_ready_o (ex_mem_ready_o),
    .mem_wb_o       (mem_wb_o),
    .mem_id_o       (mem_id_o),
    .misalign_o     (misalign_o),
    .dmem_addr_o    (dmem_addr_o),
    .dmem_valid_o   (dmem_valid_o),
    .dmem_we_o      (dmem_we_o),
    .dmem_mask_o    (dmem_mask_o),
    .dmem_wdata_o   (dmem_wdata_o),
    .dmem_rdata_i   (dmem_rdata_i),
    .dmem_ack_i     (dmem_ack_i)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Expected writeback state: valid/misalign are per-cycle, the rest is the last retirement
  logic        exp_valid, exp_mis, exp_rd_we, exp_v_known;
  logic [4:0]  exp_rd_s;
  logic [31:0] exp_rd_v, exp_pc;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    checkOutput("wb.valid", 32'(mem_wb_o.valid), 32'(exp_valid));
    checkOutput("misalign", 32'(misalign_o), 32'(exp_mis));
    checkOutput("id.valid", 32'(mem_id_o.valid), 32'(exp_valid));
    checkOutput("id.rd_s", 32'(mem_id_o.rd_s), 32'(exp_rd_s));
    checkOutput("id.rd_we", 32'(mem_id_o.rd_we), 32'(exp_rd_we));
    if (exp_v_known) checkOutput("id.rd_v", mem_id_o.rd_v, exp_rd_v);
    if (exp_valid) begin
      checkOutput("wb.rd_s", 32'(mem_wb_o.rd_s), 32'(exp_rd_s));
      checkOutput("wb.rd_we", 32'(mem_wb_o.rd_we), 32'(exp_rd_we));
      checkOutput("wb.dbg.rd_we", 32'(mem_wb_o.debug.rd_we), 32'(exp_rd_we));
      checkOutput("wb.dbg.pc", mem_wb_o.debug.pc, exp_pc);
      if (exp_v_known) begin
        checkOutput("wb.rd_v", mem_wb_o.rd_v, exp_rd_v);
        checkOutput("wb.dbg.rd_v", mem_wb_o.debug.rd_v, exp_rd_v);
      end
    end
    exp_valid = 1'b0;
    exp_mis   = 1'b0;
  endtask

  // kind: 0 = ALU, 1 = load, 2 = store; val is the ALU result or effective address
  task automatic applyStimulus(input int kind, input logic [2:0] typ, input logic [4:0] rs,
                               input logic we, input logic [31:0] val, input logic [31:0] sd,
                               input int k, input logic [31:0] rdata, input bit junk);
    logic [1:0]  off;
    logic [31:0] pc, exp_mask, exp_wdata, res;
    bit          mis;
    off = val[1:0];
    pc  = $urandom;
    mis = (kind != 0) && ((typ[1:0] == 2'b01 && off[0]) || (typ[1:0] == 2'b10 && off != 2'b00));
    checkOutput("ready.idle", 32'(ex_mem_ready_o), 32'd1);
    ex_mem_i             = '0;
    ex_mem_i.valid       = 1'b1;
    ex_mem_i.rd_s        = rs;
    ex_mem_i.rd_we       = we;
    ex_mem_i.rd_v        = val;
    ex_mem_i.is_load     = (kind == 1);
    ex_mem_i.is_store    = (kind == 2);
    ex_mem_i.ld_str_type = typ;
    ex_mem_i.debug.pc    = pc;
    ex_mem_i.debug.instr = $urandom;
    ex_mem_i.debug.rd_v  = $urandom;
    ex_mem_i.debug.rd_we = 1'($urandom);
    ex_mem_sdata_i       = sd;
    if (kind == 0 || mis) begin
      exp_valid   = 1'b1;
      exp_mis     = mis;
      exp_rd_s    = rs;
      exp_rd_we   = (kind == 0) && we && (rs != 0);
      exp_rd_v    = val;
      exp_v_known = (kind == 0);
      exp_pc      = pc;
      tick();
      ex_mem_i.valid = 1'b0;
      checkOutput("nomem.dmem_valid", 32'(dmem_valid_o), 32'd0);
      return;
    end
    tick();
    ex_mem_i.valid = 1'b0;
    exp_mask  = 32'hF;
    exp_wdata = sd;
    if (kind == 2) begin
      if (typ[1:0] == 2'b00) begin
        exp_mask  = 32'd1 << off;
        exp_wdata = (sd & 32'hFF) * 32'h0101_0101;
      end else if (typ[1:0] == 2'b01) begin
        exp_mask  = 32'd3 << off;
        exp_wdata = (sd & 32'hFFFF) * 32'h0001_0001;
      end
    end
    for (int i = 1; i <= k; i++) begin
      checkOutput("busy.ready", 32'(ex_mem_ready_o), 32'd0);
      checkOutput("busy.dmem_valid", 32'(dmem_valid_o), 32'd1);
      checkOutput("busy.addr", dmem_addr_o, val & ~32'd3);
      checkOutput("busy.we", 32'(dmem_we_o), 32'(kind == 2));
      checkOutput("busy.mask", 32'(dmem_mask_o), exp_mask);
      if (kind == 2) checkOutput("busy.wdata", dmem_wdata_o, exp_wdata);
      if (junk) begin
        ex_mem_i.valid = 1'b1;
        ex_mem_i.rd_v  = $urandom;
        ex_mem_i.rd_s  = 5'($urandom);
      end
      if (i == k) begin
        dmem_ack_i   = 1'b1;
        dmem_rdata_i = rdata;
        if (kind == 1) begin
          if (typ[1:0] == 2'b00) begin
            res = (rdata >> (8 * off)) & 32'hFF;
            if (typ == LS_B && res >= 32'd128) res = res - 32'd256;
          end else if (typ[1:0] == 2'b01) begin
            res = (rdata >> (16 * (off / 2))) & 32'hFFFF;
            if (typ == LS_H && res >= 32'd32768) res = res - 32'd65536;
          end else begin
            res = rdata;
          end
        end else begin
          res = val;
        end
        exp_valid   = 1'b1;
        exp_rd_s    = rs;
        exp_rd_we   = (kind == 1) && we && (rs != 0);
        exp_rd_v    = res;
        exp_v_known = (kind == 1);
        exp_pc      = pc;
      end else begin
        dmem_ack_i   = 1'b0;
        dmem_rdata_i = $urandom;
      end
      tick();
    end
    dmem_ack_i     = 1'b0;
    ex_mem_i.valid = 1'b0;
    checkOutput("done.dmem_valid", 32'(dmem_valid_o), 32'd0);
  endtask

  task automatic model_reset();
    exp_valid = 0; exp_mis = 0; exp_rd_we = 0; exp_rd_s = 0;
    exp_rd_v = 0; exp_pc = 0; exp_v_known = 1;
  endtask

  initial begin
    logic [2:0] ld_types [5];
    ld_types = '{LS_B, LS_H, LS_W, LS_BU, LS_HU};
    ex_mem_i = '0; ex_mem_sdata_i = 0; dmem_rdata_i = 0; dmem_ack_i = 0;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("rst.ready", 32'(ex_mem_ready_o), 32'd1);
    checkOutput("rst.wb", 32'(mem_wb_o.valid), 32'd0);
    checkOutput("rst.wb_rd_v", mem_wb_o.rd_v, 32'd0);
    checkOutput("rst.misalign", 32'(misalign_o), 32'd0);
    checkOutput("rst.dmem_valid", 32'(dmem_valid_o), 32'd0);
    checkOutput("rst.we", 32'(dmem_we_o), 32'd0);
    checkOutput("rst.mask", 32'(dmem_mask_o), 32'd0);
    checkOutput("rst.wdata", dmem_wdata_o, 32'd0);
    checkOutput("rst.addr", dmem_addr_o, 32'd0);

    applyStimulus(0, 3'd0, 5'd5, 1'b1, 32'h1234, 32'd0, 0, 32'd0, 0);
    checkOutput("pass.rd_v", mem_wb_o.rd_v, 32'h1234);
    applyStimulus(1, LS_B, 5'd7, 1'b1, 32'h103, 32'd0, 1, 32'h80FF_0000, 0);
    checkOutput("lb.rd_v", mem_wb_o.rd_v, 32'hFFFF_FF80);
    applyStimulus(1, LS_BU, 5'd7, 1'b1, 32'h103, 32'd0, 1, 32'h80FF_0000, 0);
    checkOutput("lbu.rd_v", mem_wb_o.rd_v, 32'h0000_0080);
    applyStimulus(2, LS_H, 5'd3, 1'b1, 32'h202, 32'hDEAD_BEEF, 3, 32'd0, 1);
    checkOutput("sh.rd_we", 32'(mem_wb_o.rd_we), 32'd0);
    applyStimulus(1, LS_W, 5'd9, 1'b1, 32'h101, 32'd0, 0, 32'd0, 0);
    checkOutput("mis.rd_we", 32'(mem_wb_o.rd_we), 32'd0);

    // Reset while a load is outstanding, then a stray ack afterwards
    ex_mem_i = '0; ex_mem_i.valid = 1; ex_mem_i.is_load = 1;
    ex_mem_i.ld_str_type = LS_W; ex_mem_i.rd_s = 5'd4; ex_mem_i.rd_we = 1; ex_mem_i.rd_v = 32'h400;
    tick();
    ex_mem_i.valid = 0;
    checkOutput("rstbusy.dmem_valid", 32'(dmem_valid_o), 32'd1);
    tick();
    rst_n = 1'b0;
    model_reset();
    tick();
    rst_n = 1'b1;
    checkOutput("rstbusy.after_valid", 32'(dmem_valid_o), 32'd0);
    checkOutput("rstbusy.ready", 32'(ex_mem_ready_o), 32'd1);
    dmem_ack_i = 1'b1; dmem_rdata_i = 32'h5555_AAAA;
    tick();
    dmem_ack_i = 1'b0;
    checkOutput("lateack.dmem_valid", 32'(dmem_valid_o), 32'd0);
    checkOutput("lateack.ready", 32'(ex_mem_ready_o), 32'd1);

    applyStimulus(0, 3'd0, 5'd1, 1'b1, 32'h11, 32'd0, 0, 32'd0, 0);
    applyStimulus(1, LS_W, 5'd2, 1'b1, 32'h800, 32'd0, 1, 32'hCAFE_F00D, 0);
    checkOutput("b2b.lw", mem_wb_o.rd_v, 32'hCAFE_F00D);
    applyStimulus(0, 3'd0, 5'd3, 1'b1, 32'h33, 32'd0, 0, 32'd0, 0);
    applyStimulus(1, LS_H, 5'd0, 1'b1, 32'h902, 32'd0, 2, 32'h8001_7FFF, 0);
    checkOutput("b2b.x0", 32'(mem_wb_o.rd_we), 32'd0);

    for (int n = 0; n < 300; n++) begin
      int          kind;
      logic [2:0]  typ;
      logic [31:0] addr;
      kind = $urandom_range(0, 2);
      typ  = (kind == 2) ? 3'($urandom_range(0, 2)) : ld_types[$urandom_range(0, 4)];
      addr = $urandom;
      if ($urandom_range(0, 1) == 0) addr[1:0] = 2'b00;
      applyStimulus(kind, typ, ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom),
                    1'($urandom), addr, $urandom, $urandom_range(1, 4), $urandom,
                    1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/orion_mem_stage.md
# orion_mem_stage

Memory stage of the Orion RV32I pipeline, between execute and writeback. It accepts one `ex_mem_t` bundle per handshake and issues loads and stores to the data-memory port using a valid/ack handshake. It formats load data by sign- or zero-extension and generates store byte masks. It produces the registered `mem_wb_t` bundle, plus a `mem_id_t` forwarding copy for decode.

## Interface
Parameters (from `orion_types`, not overridden):
- `XLEN`, 32, register/data width
- `ADDRW`, 32, data-memory address width
- `MASKW`, 4, byte-mask width

Ports:
- `clk`  in  1  single clock; all state updates on rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `ex_mem_i`  in  `ex_mem_t`  execute result; `rd_v` is the effective address for load/store
- `ex_mem_sdata_i`  in  XLEN  store data (rs2), qualified with `ex_mem_i.valid`
- `ex_mem_ready_o`  out  1  stage can accept `ex_mem_i` this cycle; execute stalls when 0
- `mem_wb_o`  out  `mem_wb_t`  registered result to writeback
- `mem_id_o`  out  `mem_id_t`  forwarding copy of `mem_wb_o` (valid, rd_we, rd_s, rd_v)
- `misalign_o`  out  1  one-cycle pulse: misaligned access was dropped
- `dmem_addr_o`  out  ADDRW  word-aligned address (`rd_v & ~3`)
- `dmem_valid_o`  out  1  request valid
- `dmem_we_o`  out  1  1 = store
- `dmem_mask_o`  out  MASKW  byte enables
- `dmem_wdata_o`  out  DATAW  lane-replicated store data
- `dmem_rdata_i`  in  DATAW  load data, valid in the `dmem_ack_i` cycle
- `dmem_ack_i`  in  1  request complete

## Operation
- FSM states: IDLE and BUSY.
- `ex_mem_ready_o` = (state == IDLE). A transfer occurs when `ex_mem_i.valid && ex_mem_ready_o`.
- **Non-memory transfer** (`!is_load && !is_store`): copy valid, rd_s, rd_we, rd_v and debug into the `mem_wb_o` register. State stays IDLE.
- **Aligned load/store transfer:**
  - Latch rd_s, rd_we, ld_str_type, is_load, debug and the low address bits.
  - Drive the `dmem_*` registers and go to BUSY.
- **Misalignment:** halfword with `addr[0]=1`, or word with `addr[1:0]!=0`.
  - No bus request is made.
  - `mem_wb_o` is issued next cycle with `rd_we=0`.
  - `misalign_o` pulses for one cycle. State stays IDLE.
- **BUSY:**
  - Hold `dmem_valid_o=1` with addr, we, mask and wdata stable until `dmem_ack_i`.
  - On ack, load `mem_wb_o` (valid=1) and return to IDLE. `dmem_valid_o` drops the next cycle.
- **Store encoding** (off = `addr[1:0]`):
  - SB: wdata = `{4{sdata[7:0]}}`, mask = `4'b0001<<off`.
  - SH: wdata = `{2{sdata[15:0]}}`, mask = `4'b0011<<off`.
  - SW: wdata = sdata, mask = `4'hF`.
  - `dmem_we_o=1`. Result has `rd_we=0`.
- **Load encoding:** `dmem_we_o=0`, mask = `4'hF`.
  - LB/LBU take byte `rdata[8*off+:8]`.
  - LH/LHU take half `rdata[16*addr[1]+:16]`.
  - B/H are sign-extended; BU/HU are zero-extended; LW passes `rdata` through.
  - Result `rd_v` is the formatted data; `rd_we` is as latched.
- `rd_we` is forced to 0 whenever `rd_s==0`.
- Debug: `debug.rd_v` and `debug.rd_we` are overwritten with the final values. All other debug fields pass through unchanged.
- `mem_wb_o.valid` is 1 for exactly one cycle per accepted instruction, and 0 otherwise. The other `mem_wb_o` fields hold their last value.
- `mem_id_o` is driven combinationally from the `mem_wb_o` register.
- `dmem_ack_i` is ignored in IDLE.

## Timing
- **Reset** (edge with `rst_n=0`):
  - State = IDLE.
  - `mem_wb_o` all-zero, `misalign_o=0`.
  - `dmem_valid_o`, `dmem_we_o`, `dmem_mask_o`, `dmem_wdata_o`, `dmem_addr_o` = 0.
  - `ex_mem_ready_o` reads 1 from the first cycle after reset.
- **Non-memory latency:** transfer in cycle N → `mem_wb_o.valid` in cycle N+1. Throughput is 1/cycle.
- **Memory latency:** transfer in N → `dmem_valid_o` in N+1 → ack in cycle N+k (k≥1; same-cycle ack is legal) → `mem_wb_o.valid` in N+k+1.
- Ready is 0 in cycles N+1..N+k. The next transfer is possible in N+k+1.
- **Reset mid-BUSY:**
  - The transaction is abandoned and `dmem_valid_o` is 0 after the reset edge.
  - No `mem_wb_o.valid` is produced for it.
  - A late ack is ignored.
- **Input rules:** `ex_mem_i` is don't-care when `ex_mem_ready_o=0`; execute must hold it. `ex_mem_sdata_i` is sampled only at the transfer edge.

## Test plan
- **Pass-through:** after reset, transfer ALU result (rd_s=5, rd_v=0x1234, rd_we=1) → next cycle `mem_wb_o` valid, rd_v=0x1234, rd_we=1; `dmem_valid_o` stays 0.
- **Byte loads:** LB at 0x103 with rdata=0x80FF_0000 and ack on the first BUSY cycle → addr=0x100, mask=F, rd_v=0xFFFF_FF80. LBU at the same address → rd_v=0x0000_0080.
- **Halfword store:** SH at 0x202 with sdata=0xDEAD_BEEF, ack 3 cycles after request → wdata=0xBEEF_BEEF, mask=4'b1100, we=1 held 3 cycles; ready low 3 cycles; `mem_wb_o` valid with rd_we=0.
- **Misaligned load:** LW at 0x101 → no `dmem_valid_o`, `misalign_o` pulses once, `mem_wb_o` valid with rd_we=0.
- **Reset mid-BUSY:** LW outstanding, `rst_n=0` for one cycle, ack arrives after → `dmem_valid_o`=0 after the reset edge, no `mem_wb_o.valid`, ready=1.
- **Back-to-back:** ALU, LW (same-cycle ack, rdata=0xCAFE_F00D), ALU, LH to x0 → `mem_wb_o.valid` in cycles 1, 3, 4, …; LW rd_v=0xCAFE_F00D; the x0 load retires with rd_we=0; `mem_id_o` matches `mem_wb_o` every cycle.
